mem_responder: RTL and testbench

Memory-side responder for the multicycle RV32 core's unified instruction/data bus. It accepts one address/data/funct3 request at a time from the core. After a parameterised number of wait states it completes the request with a one-cycle `Ready` pulse. It performs byte/halfword/word stores into a word-organised RAM and returns sign- or zero-extended load data. It sits outside the CPU, between the datapath's memory address/write-data/read-data signals and the controller's wait logic.

---
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle RV32 core bus.
// Takes one request at a time, waits LATENCY cycles, then completes it with
// a one-cycle Ready pulse. Handles byte/halfword/word stores as a
// read-modify-write of a word-organised RAM and returns extended load data.
module mem_responder #(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WD,
    input  logic [2:0]  funct3,
    output logic [31:0] RD,
    output logic        Ready,
    output logic        Misaligned
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter value on the final wait-state cycle (unused when LATENCY is 0).
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              ready_reg;
    logic              is_store_reg;
    logic              mis_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [1:0]        lane_reg;
    logic [31:0]       wd_reg;
    logic [2:0]        f3_reg;

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [31:0]       rdata_reg;
    logic [31:0]       merged;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_en;

    logic              accept;
    logic              mis_in;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_word;

    // Address bits above the RAM are deliberately ignored so accesses wrap.
    logic unused_adr;
    assign unused_adr = ^Adr[31:ADDR_W+2];

    assign accept = (state_reg == S_IDLE) && (MemRead || MemWrite);

    // Alignment check on the incoming request, latched at acceptance.
    always_comb begin
        mis_in = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            mis_in = Adr[0];
        end else if (funct3[1:0] != 2'b00) begin
            mis_in = |Adr[1:0];
        end
    end

    // Next-state and wait-state counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
                    cnt_next   = 4'd0;
                end
            end
            S_WAIT: begin
                if (cnt_reg == LAT_LAST) begin
                    state_next = S_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control state plus the latched request copy; reset wins over a request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 4'd0;
            ready_reg    <= 1'b0;
            is_store_reg <= 1'b0;
            mis_reg      <= 1'b0;
            idx_reg      <= '0;
            lane_reg     <= 2'd0;
            wd_reg       <= 32'h0;
            f3_reg       <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= (state_next == S_RESP);
            if (accept) begin
                is_store_reg <= MemWrite;
                mis_reg      <= mis_in;
                idx_reg      <= Adr[ADDR_W+1:2];
                lane_reg     <= Adr[1:0];
                wd_reg       <= WD;
                f3_reg       <= funct3;
            end
        end
    end

    // Read the word the request will address next cycle so it is already
    // registered by RESP, even with zero wait states.
    assign rd_idx = accept ? Adr[ADDR_W+1:2] : idx_reg;

    // Commit on the edge closing RESP; a reset on that edge cancels it.
    assign wr_en = (state_reg == S_RESP) && is_store_reg && !mis_reg && !reset;

    // Byte-lane merge of store data into the previously read word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       lane_en;
        logic [7:0] src;

        // Choose whether this lane is written and which store byte feeds it.
        always_comb begin
            lane_en = 1'b1;
            src     = wd_reg[8*gi +: 8];
            if (f3_reg[1:0] == 2'b00) begin
                lane_en = (lane_reg == 2'(gi));
                src     = wd_reg[7:0];
            end else if (f3_reg[1:0] == 2'b01) begin
                lane_en = (lane_reg[1] == 1'(gi / 2));
                src     = wd_reg[8*(gi % 2) +: 8];
            end
        end

        assign merged[8*gi +: 8] = lane_en ? src : rdata_reg[8*gi +: 8];
    end

    // Block RAM: one synchronous write port and one registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx_reg] <= merged;
        end
        rdata_reg <= mem[rd_idx];
    end

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        byte_sel = rdata_reg[{lane_reg, 3'b000} +: 8];
        half_sel = lane_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
        case (f3_reg[1:0])
            2'b00:   load_word = {{24{~f3_reg[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_word = {{16{~f3_reg[2] & half_sel[15]}}, half_sel};
            default: load_word = rdata_reg;
        endcase
    end

    // Data and error flag are only visible during the Ready pulse.
    assign Ready      = ready_reg;
    assign Misaligned = ready_reg & mis_reg;
    assign RD         = (ready_reg && !is_store_reg && !mis_reg) ? load_word : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LATENCY 1, 0, 3) share the
// address/data/reset stimulus but have private request lines. Expected
// values come from directed constants and a byte-addressed memory model.
module tb_mem_responder;

    localparam int AW    = 10;
    localparam int BYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mem_read, mem_write;
    logic [31:0] adr, wd;
    logic [2:0]  f3;
    logic [31:0] rd_o [3];
    logic [2:0]  ready_o, mis_o;

    int lat_of [3] = '{1, 0, 3};
    int checks = 0;
    int errors = 0;

    // Model memory: one byte per key, key = instance*BYTES + wrapped byte address.
    logic [7:0] mdl [int];

    typedef struct packed {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] data;
        logic [2:0]  f;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } op_t;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(AW), .LATENCY(1), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .Adr(adr), .WD(wd), .funct3(f3),
        .RD(rd_o[0]), .Ready(ready_o[0]), .Misaligned(mis_o[0]));

    mem_responder #(.ADDR_W(AW), .LATENCY(0), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .Adr(adr), .WD(wd), .funct3(f3),
        .RD(rd_o[1]), .Ready(ready_o[1]), .Misaligned(mis_o[1]));

    mem_responder #(.ADDR_W(AW), .LATENCY(3), .INIT_FILE("")) dut2 (
        .clk(clk), .reset(reset), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
        .Adr(adr), .WD(wd), .funct3(f3),
        .RD(rd_o[2]), .Ready(ready_o[2]), .Misaligned(mis_o[2]));

    function automatic int nbytes(logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_mis(logic [31:0] a, logic [2:0] f);
        return (int'(a[1:0]) % nbytes(f)) != 0;
    endfunction

    function automatic int key(int d, logic [31:0] a);
        return d * BYTES + int'(a[AW+1:0]);
    endfunction

    task automatic model_store(input int d, input logic [31:0] a, input logic [31:0] data,
                               input logic [2:0] f);
        if (!model_mis(a, f)) begin
            for (int i = 0; i < nbytes(f); i++) begin
                mdl[key(d, a + 32'(i))] = 8'((data >> (8 * i)) & 32'hFF);
            end
        end
    endtask

    task automatic model_load(input int d, input logic [31:0] a, input logic [2:0] f,
                              output logic [31:0] v, output bit mis, output bit known);
        int n;
        n = nbytes(f);
        mis = model_mis(a, f);
        known = 1'b1;
        v = 32'h0;
        if (mis) return;
        for (int i = 0; i < n; i++) begin
            int k;
            k = key(d, a + 32'(i));
            if (!mdl.exists(k)) known = 1'b0;
            else v = v | (32'(mdl[k]) << (8 * i));
        end
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    endtask

    // Drive one request to instance d from a negedge, scramble the shared
    // inputs while it is in flight, and report what the Ready pulse carried.
    // Returns at the negedge of the IDLE cycle following the pulse.
    task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] data, input logic [2:0] f,
                          output int lat, output logic [31:0] rdv, output logic misv,
                          output bit pulse_ok, output bit quiet_ok);
        adr = a; wd = data; f3 = f;
        mem_write[d] = w; mem_read[d] = r;
        lat = -1; rdv = 32'h0; misv = 1'b0; pulse_ok = 1'b0; quiet_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready_o[d] === 1'b1) begin
                lat = k; rdv = rd_o[d]; misv = mis_o[d];
                break;
            end
            if (rd_o[d] !== 32'h0 || mis_o[d] !== 1'b0) quiet_ok = 1'b0;
            adr = $urandom; wd = $urandom; f3 = 3'($urandom);
        end
        mem_write[d] = 1'b0; mem_read[d] = 1'b0;
        @(negedge clk);
        pulse_ok = (ready_o[d] === 1'b0);
        $display("dut%0d %s%s adr=%h wd=%h f3=%0d -> lat=%0d rd=%h mis=%0b",
                 d, w ? "W" : "-", r ? "R" : "-", a, data, f, lat, rdv, misv);
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_write[0] = 1'b1; adr = 32'h40; wd = 32'hCAFEF00D; f3 = 3'd2;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready_o[d] !== 1'b0 || rd_o[d] !== 32'h0 || mis_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d ready=%b rd=%h mis=%b need 0/0/0",
                         d, ready_o[d], rd_o[d], mis_o[d]);
            end
        end
        reset = 1'b0; mem_write = 3'b0;
        @(negedge clk);
    endtask

    task automatic test_word_roundtrip();
        op_t ops [2] = '{
            '{1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 3'd2, 32'h0,        1'b0},
            '{1'b0, 1'b1, 32'h40, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0}};
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        foreach (ops[i]) begin
            access(0, ops[i].w, ops[i].r, ops[i].a, ops[i].data, ops[i].f,
                   lat, rdv, misv, pulse_ok, quiet_ok);
            checks++;
            if (lat !== 2 || !pulse_ok || !quiet_ok) begin
                errors++;
                $display("FAIL word_timing[%0d] lat=%0d pulse=%0b quiet=%0b need lat=2 pulse=1 quiet=1",
                         i, lat, pulse_ok, quiet_ok);
            end
            checks++;
            if (rdv !== ops[i].exp_rd || misv !== ops[i].exp_mis) begin
                errors++;
                $display("FAIL word_data[%0d] rd=%h mis=%0b need rd=%h mis=%0b",
                         i, rdv, misv, ops[i].exp_rd, ops[i].exp_mis);
            end
        end
    endtask

    task automatic test_lanes();
        op_t ops [7] = '{
            '{1'b1, 1'b0, 32'h41, 32'h0000007F, 3'd0, 32'h0,        1'b0},
            '{1'b1, 1'b0, 32'h42, 32'h00008001, 3'd1, 32'h0,        1'b0},
            '{1'b0, 1'b1, 32'h40, 32'h0,        3'd2, 32'h80017FEF, 1'b0},
            '{1'b0, 1'b1, 32'h43, 32'h0,        3'd0, 32'hFFFFFF80, 1'b0},
            '{1'b0, 1'b1, 32'h43, 32'h0,        3'd4, 32'h00000080, 1'b0},
            '{1'b0, 1'b1, 32'h42, 32'h0,        3'd1, 32'hFFFF8001, 1'b0},
            '{1'b0, 1'b1, 32'h42, 32'h0,        3'd5, 32'h00008001, 1'b0}};
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        foreach (ops[i]) begin
            access(0, ops[i].w, ops[i].r, ops[i].a, ops[i].data, ops[i].f,
                   lat, rdv, misv, pulse_ok, quiet_ok);
            checks++;
            if (lat !== 2 || !pulse_ok || !quiet_ok) begin
                errors++;
                $display("FAIL lanes_timing[%0d] lat=%0d pulse=%0b quiet=%0b need lat=2 pulse=1 quiet=1",
                         i, lat, pulse_ok, quiet_ok);
            end
            checks++;
            if (rdv !== ops[i].exp_rd || misv !== ops[i].exp_mis) begin
                errors++;
                $display("FAIL lanes_data[%0d] rd=%h mis=%0b need rd=%h mis=%0b",
                         i, rdv, misv, ops[i].exp_rd, ops[i].exp_mis);
            end
        end
    endtask

    task automatic test_misaligned();
        op_t ops [6] = '{
            '{1'b1, 1'b0, 32'h41, 32'h12345678, 3'd2, 32'h0,        1'b1},
            '{1'b0, 1'b1, 32'h40, 32'h0,        3'd2, 32'h80017FEF, 1'b0},
            '{1'b0, 1'b1, 32'h43, 32'h0,        3'd1, 32'h0,        1'b1},
            '{1'b1, 1'b0, 32'h43, 32'h0000AAAA, 3'd1, 32'h0,        1'b1},
            '{1'b0, 1'b1, 32'h42, 32'h0,        3'd2, 32'h0,        1'b1},
            '{1'b0, 1'b1, 32'h40, 32'h0,        3'd2, 32'h80017FEF, 1'b0}};
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        foreach (ops[i]) begin
            access(0, ops[i].w, ops[i].r, ops[i].a, ops[i].data, ops[i].f,
                   lat, rdv, misv, pulse_ok, quiet_ok);
            checks++;
            if (lat !== 2 || !pulse_ok || !quiet_ok) begin
                errors++;
                $display("FAIL misaligned_timing[%0d] lat=%0d pulse=%0b quiet=%0b need lat=2 pulse=1 quiet=1",
                         i, lat, pulse_ok, quiet_ok);
            end
            checks++;
            if (rdv !== ops[i].exp_rd || misv !== ops[i].exp_mis) begin
                errors++;
                $display("FAIL misaligned_data[%0d] rd=%h mis=%0b need rd=%h mis=%0b",
                         i, rdv, misv, ops[i].exp_rd, ops[i].exp_mis);
            end
        end
    endtask

    task automatic test_dual_request();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        access(0, 1'b1, 1'b1, 32'h44, 32'h0BADF00D, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (lat !== 2 || rdv !== 32'h0 || misv !== 1'b0) begin
            errors++;
            $display("FAIL dual_store lat=%0d rd=%h mis=%0b need lat=2 rd=0 mis=0", lat, rdv, misv);
        end
        access(0, 1'b0, 1'b1, 32'h44, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (rdv !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL dual_readback rd=%h need 0badf00d", rdv);
        end
    endtask

    task automatic test_alias();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        access(0, 1'b1, 1'b0, 32'h40 + 32'(BYTES), 32'h13579BDF, 3'd2,
               lat, rdv, misv, pulse_ok, quiet_ok);
        access(0, 1'b0, 1'b1, 32'h40, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (rdv !== 32'h13579BDF) begin
            errors++;
            $display("FAIL alias_low rd=%h need 13579bdf", rdv);
        end
        access(0, 1'b0, 1'b1, 32'hFFFFF040, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (rdv !== 32'h13579BDF) begin
            errors++;
            $display("FAIL alias_high rd=%h need 13579bdf", rdv);
        end
    endtask

    task automatic test_reset_pending();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        reset = 1'b1; mem_write[0] = 1'b1; adr = 32'h40; wd = 32'h0; f3 = 3'd2;
        @(negedge clk);
        checks++;
        if (ready_o[0] !== 1'b0 || rd_o[0] !== 32'h0 || mis_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending_outputs ready=%b rd=%h mis=%b need 0/0/0",
                     ready_o[0], rd_o[0], mis_o[0]);
        end
        @(negedge clk);
        reset = 1'b0; mem_write[0] = 1'b0;
        @(negedge clk);
        access(0, 1'b0, 1'b1, 32'h40, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (rdv !== 32'h13579BDF) begin
            errors++;
            $display("FAIL reset_pending_ram rd=%h need 13579bdf", rdv);
        end
    endtask

    task automatic test_latency();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        for (int d = 0; d < 3; d++) begin
            access(d, 1'b1, 1'b0, 32'h80, 32'hA5A50000 | 32'(d), 3'd2,
                   lat, rdv, misv, pulse_ok, quiet_ok);
            checks++;
            if (lat !== lat_of[d] + 1 || !pulse_ok || !quiet_ok) begin
                errors++;
                $display("FAIL latency_store dut%0d lat=%0d pulse=%0b quiet=%0b need lat=%0d",
                         d, lat, pulse_ok, quiet_ok, lat_of[d] + 1);
            end
            access(d, 1'b0, 1'b1, 32'h80, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
            checks++;
            if (lat !== lat_of[d] + 1 || rdv !== (32'hA5A50000 | 32'(d))) begin
                errors++;
                $display("FAIL latency_load dut%0d lat=%0d rd=%h need lat=%0d rd=%h",
                         d, lat, rdv, lat_of[d] + 1, 32'hA5A50000 | 32'(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 3; d++) begin
            int t [3];
            int n;
            bit data_ok;
            n = 0; data_ok = 1'b1;
            mem_read[d] = 1'b1; adr = 32'h80; f3 = 3'd2;
            for (int k = 1; k <= 40 && n < 3; k++) begin
                @(negedge clk);
                if (ready_o[d] === 1'b1) begin
                    t[n] = k; n++;
                    if (rd_o[d] !== (32'hA5A50000 | 32'(d))) data_ok = 1'b0;
                end
            end
            mem_read[d] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            $display("dut%0d back-to-back reads: %0d pulses at %0d %0d %0d",
                     d, n, t[0], t[1], t[2]);
            checks++;
            if (n != 3 || t[0] != lat_of[d] + 1 || t[1] - t[0] != lat_of[d] + 2 ||
                t[2] - t[1] != lat_of[d] + 2 || !data_ok) begin
                errors++;
                $display("FAIL back_to_back dut%0d pulses=%0d at %0d,%0d,%0d data_ok=%0b need 3 at %0d, +%0d, +%0d",
                         d, n, t[0], t[1], t[2], data_ok, lat_of[d] + 1, lat_of[d] + 2, lat_of[d] + 2);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        bit seen;
        mem_write[2] = 1'b1; adr = 32'h80; wd = 32'hFFFFFFFF; f3 = 3'd2;
        @(negedge clk);
        reset = 1'b1; mem_write[2] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready_o[2] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_wait_ready Ready pulsed after reset, need no pulse");
        end
        access(2, 1'b0, 1'b1, 32'h80, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (rdv !== 32'hA5A50002) begin
            errors++;
            $display("FAIL reset_wait_ram rd=%h need a5a50002", rdv);
        end
    endtask

    task automatic test_reset_in_resp();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        bit hit;
        hit = 1'b0;
        mem_write[2] = 1'b1; adr = 32'h80; wd = 32'h11111111; f3 = 3'd2;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready_o[2] === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        reset = 1'b1; mem_write[2] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (!hit || ready_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_pulse reached_resp=%0b ready_after=%b need 1/0", hit, ready_o[2]);
        end
        @(negedge clk);
        access(2, 1'b0, 1'b1, 32'h80, 32'h0, 3'd2, lat, rdv, misv, pulse_ok, quiet_ok);
        checks++;
        if (rdv !== 32'hA5A50002) begin
            errors++;
            $display("FAIL reset_resp_ram rd=%h need a5a50002", rdv);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rdv; logic misv; bit pulse_ok, quiet_ok;
        logic [31:0] a, data, hi, exp_rd;
        logic [2:0] f;
        bit w, r, exp_mis, known;
        int sel;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 80; i++) begin
                hi = $urandom;
                data = $urandom;
                if (i < 16) begin
                    a = 32'h200 + 32'(4 * i); f = 3'd2; w = 1'b1; r = 1'b0;
                end else begin
                    a = (hi & 32'hFFFFF000) | (32'h200 + 32'($urandom_range(0, 63)));
                    f = 3'($urandom);
                    sel = $urandom_range(0, 2);
                    w = (sel != 0); r = (sel != 1);
                end
                if (w) begin
                    exp_mis = model_mis(a, f); exp_rd = 32'h0; known = 1'b1;
                    model_store(d, a, data, f);
                end else begin
                    model_load(d, a, f, exp_rd, exp_mis, known);
                end
                access(d, w, r, a, data, f, lat, rdv, misv, pulse_ok, quiet_ok);
                checks++;
                if (lat !== lat_of[d] + 1 || !pulse_ok || !quiet_ok) begin
                    errors++;
                    $display("FAIL random_timing dut%0d #%0d lat=%0d pulse=%0b quiet=%0b need lat=%0d",
                             d, i, lat, pulse_ok, quiet_ok, lat_of[d] + 1);
                end
                if (known) begin
                    checks++;
                    if (rdv !== exp_rd || misv !== exp_mis) begin
                        errors++;
                        $display("FAIL random_data dut%0d #%0d adr=%h f3=%0d rd=%h mis=%0b need rd=%h mis=%0b",
                                 d, i, a, f, rdv, misv, exp_rd, exp_mis);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 3'b0; mem_write = 3'b0;
        adr = 32'h0; wd = 32'h0; f3 = 3'd0;
        test_reset();
        test_word_roundtrip();
        test_lanes();
        test_misaligned();
        test_dual_request();
        test_alias();
        test_reset_pending();
        test_latency();
        test_back_to_back();
        test_reset_in_wait();
        test_reset_in_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
